// File: rtl/data_sram_resp_pkg.sv
// Shared types and constants for the data SRAM responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package data_sram_resp_pkg;

  localparam int DATA_W  = 32;
  localparam int WSTRB_W = 4;

  // err_cause encodings; both bits set means out of range and misaligned
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  typedef enum logic [1:0] {
    ACC_IDLE  = 2'b00,
    ACC_READ  = 2'b01,
    ACC_WRITE = 2'b10
  } acc_e;

  // Combine the two independent error conditions into one cause code.
  function automatic logic [1:0] err_cause_f(input logic out_of_range,
                                             input logic misaligned);
    logic [1:0] c;
    c = ERR_NONE;
    if (out_of_range) c = c | ERR_RANGE;
    if (misaligned)   c = c | ERR_ALIGN;
    return c;
  endfunction

endpackage

// File: rtl/data_sram_resp_array.sv
// Byte-write-enabled 2**ADDR_W x 32 array, read-first registered port plus async debug read.
// Latency: rdata 1 cycle after en; dbg_rdata combinational.
// Backpressure: none, an access is accepted every cycle en is high.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (output register only)
//   en              access strobe; loads rdata_q, otherwise rdata holds
//   we              per-byte write enables (already qualified by the caller)
//   addr            word index
//   wdata           write data
//   rd_zero         load zero instead of the array word (access decoded as invalid)
//   rdata           registered read-first data
//   dbg_addr        backdoor word index
//   dbg_rdata       combinational backdoor read
module sram_bytewe_array
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WSTRB_W-1:0]  we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                rd_zero,
  output logic [DATA_W-1:0]   rdata,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // The array deliberately has no reset so its contents survive reset and
  // a write coincident with reset still lands.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WSTRB_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read-first: the word sampled here is the value before this edge's write.
  always_comb begin
    rdata_d = rdata_q;
    if (en) rdata_d = rd_zero ? '0 : mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata     = rdata_q;
  assign dbg_rdata = mem[dbg_addr];

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: decodes CPU accesses, drives the array, captures first error, counts accesses.
// Latency: data_sram_rdata valid 1 cycle after the accepted access; dbg_rdata combinational.
// Backpressure: none, every enabled cycle is accepted.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   data_sram_en/wen/addr/wdata access from execute (wen != 0 means write)
//   data_sram_rdata             read data for the memory stage
//   err_valid/err_addr/err_cause sticky first-error capture
//   rd_cnt, wr_cnt              wrapping access counters
//   dbg_addr, dbg_rdata         backdoor word read
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_sram_en,
  input  logic [3:0]         data_sram_wen,
  input  logic [31:0]        data_sram_addr,
  input  logic [31:0]        data_sram_wdata,
  output logic [31:0]        data_sram_rdata,
  output logic               err_valid,
  output logic [31:0]        err_addr,
  output logic [1:0]         err_cause,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic [CNT_W-1:0]   wr_cnt,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [31:0]        dbg_rdata
);

  // 33-bit limit so ADDR_W up to 30 does not overflow the byte span.
  localparam logic [32:0] RANGE_LIMIT = 33'd1 << (ADDR_W + 2);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0]        off;
  logic               in_range;
  logic               misaligned;
  logic [ADDR_W-1:0]  idx;
  acc_e               acc;
  logic [WSTRB_W-1:0] arr_we;
  logic               arr_en;

  logic               err_valid_d, err_valid_q;
  logic [31:0]        err_addr_d,  err_addr_q;
  logic [1:0]         err_cause_d, err_cause_q;
  logic [CNT_W-1:0]   rd_cnt_d,    rd_cnt_q;
  logic [CNT_W-1:0]   wr_cnt_d,    wr_cnt_q;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the compare.
  always_comb begin
    off        = data_sram_addr - BASE_ADDR;
    in_range   = ({1'b0, off} < RANGE_LIMIT);
    misaligned = |data_sram_addr[1:0];
    idx        = off[ADDR_W+1:2];
  end

  always_comb begin
    acc = ACC_IDLE;
    if (data_sram_en) acc = (data_sram_wen != '0) ? ACC_WRITE : ACC_READ;
  end

  // Out-of-range writes must not alias into the array.
  always_comb begin
    arr_en = (acc != ACC_IDLE);
    arr_we = '0;
    if (acc == ACC_WRITE && in_range) arr_we = data_sram_wen;
  end

  sram_bytewe_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .en        (arr_en),
    .we        (arr_we),
    .addr      (idx),
    .wdata     (data_sram_wdata),
    .rd_zero   (~in_range),
    .rdata     (data_sram_rdata),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  // First error wins; later errors leave the capture untouched until reset.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    if (acc != ACC_IDLE && (!in_range || misaligned) && !err_valid_q) begin
      err_valid_d = 1'b1;
      err_addr_d  = data_sram_addr;
      err_cause_d = err_cause_f(!in_range, misaligned);
    end
  end

  // Counters count every accepted access, in range or not, and wrap.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (acc == ACC_READ)  rd_cnt_d = rd_cnt_q + CNT_ONE;
    if (acc == ACC_WRITE) wr_cnt_d = wr_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= ERR_NONE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
  assign err_cause = err_cause_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          CNT_W  = 4;   // narrow so counter wrap is reachable

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [3:0]        wen = 4'h0;
  logic [31:0]       addr = 32'h0;
  logic [31:0]       wdata = 32'h0;
  logic [31:0]       rdata;
  logic              err_valid;
  logic [31:0]       err_addr;
  logic [1:0]        err_cause;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt;
  logic [ADDR_W-1:0] dbg_addr = '0;
  logic [31:0]       dbg_rdata;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .err_valid       (err_valid),
    .err_addr        (err_addr),
    .err_cause       (err_cause),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt),
    .dbg_addr        (dbg_addr),
    .dbg_rdata       (dbg_rdata)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_rdata = 32'h0;
  bit          m_rd_known = 1'b0;
  bit          m_err_v = 1'b0;
  logic [31:0] m_err_addr = 32'h0;
  logic [1:0]  m_err_cause = 2'b00;
  int          m_rd = 0, m_wr = 0;
  bit          chk_on = 1'b0;

  int n_vec = 0, n_bad = 0;

  function automatic bit m_in_range(input logic [31:0] a);
    longint o;
    o = longint'(a) - longint'(BASE);
    return (o >= 0) && (o < 4 * longint'(DEPTH));
  endfunction

  task automatic model_update(input bit r, input bit e, input logic [3:0] w,
                              input logic [31:0] a, input logic [31:0] d);
    bit ir;
    int wi;
    ir = m_in_range(a);
    wi = int'((a - BASE) >> 2) % DEPTH;
    if (e) begin
      if (!r) begin
        if (w != 4'h0) m_wr++; else m_rd++;
        if (ir) begin
          m_rdata = m_mem[wi];
          m_rd_known = m_known[wi];
        end else begin
          m_rdata = 32'h0;
          m_rd_known = 1'b1;
        end
        if (!m_err_v && (!ir || a[1:0] != 2'b00)) begin
          m_err_v = 1'b1;
          m_err_addr = a;
          m_err_cause = {a[1:0] != 2'b00, !ir};
        end
      end
      // memory is written even when reset is high
      if (w != 4'h0 && ir) begin
        for (int i = 0; i < 4; i++)
          if (w[i]) m_mem[wi][8*i +: 8] = d[8*i +: 8];
        if (w == 4'hf) m_known[wi] = 1'b1;
      end
    end
    if (r) begin
      m_rdata = 32'h0; m_rd_known = 1'b1;
      m_rd = 0; m_wr = 0;
      m_err_v = 1'b0; m_err_addr = 32'h0; m_err_cause = 2'b00;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: every negedge, all outputs against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [CNT_W-1:0] erd, ewr;
      erd = m_rd[CNT_W-1:0];
      ewr = m_wr[CNT_W-1:0];
      if (m_rd_known) chk("rdata", rdata, m_rdata);
      chk("err_valid", {31'd0, err_valid}, {31'd0, m_err_v});
      chk("err_addr", err_addr, m_err_addr);
      chk("err_cause", {30'd0, err_cause}, {30'd0, m_err_cause});
      chk("rd_cnt", {28'd0, rd_cnt}, {28'd0, erd});
      chk("wr_cnt", {28'd0, wr_cnt}, {28'd0, ewr});
      if (m_known[dbg_addr]) chk("dbg_rdata", dbg_rdata, m_mem[dbg_addr]);
    end
  end

  // Drive one vector (called just after a negedge), apply it, return at the next negedge.
  task automatic step(input bit r, input bit e, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    reset = r; en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    model_update(r, e, w, a, d);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    step(1'b0, 1'b1, w, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, 4'h0, a, 32'hFFFF_FFFF);
  endtask

  task automatic rst1();
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'h0;
      m_known[i] = 1'b0;
    end
    @(negedge clk);
    rst1();
    rst1();
    chk_on = 1'b1;
    // reset state pins
    chk("pin reset rdata", rdata, 32'h0);
    chk("pin reset err_valid", {31'd0, err_valid}, 32'd0);
    chk("pin reset rd_cnt", {28'd0, rd_cnt}, 32'd0);

    // write then read
    dbg_addr = 12'd4;
    wr(32'h10, 4'hf, 32'hDEAD_BEEF);
    rd(32'h10);
    chk("pin wr/rd rdata", rdata, 32'hDEAD_BEEF);
    chk("pin wr/rd wr_cnt", {28'd0, wr_cnt}, 32'd1);
    chk("pin wr/rd rd_cnt", {28'd0, rd_cnt}, 32'd1);

    // byte lanes
    dbg_addr = 12'd8;
    wr(32'h20, 4'hf, 32'h1122_3344);
    wr(32'h20, 4'b0101, 32'hAABB_CCDD);
    chk("pin lane read-first", rdata, 32'h1122_3344);
    rd(32'h20);
    chk("pin lane rdata", rdata, 32'h11BB_33DD);
    chk("pin lane dbg", dbg_rdata, 32'h11BB_33DD);

    // hold on idle, wen ignored
    dbg_addr = 12'd4;
    rd(32'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'hf, 32'h10, 32'h0);
    chk("pin idle rdata", rdata, 32'hDEAD_BEEF);
    chk("pin idle dbg", dbg_rdata, 32'hDEAD_BEEF);
    chk("pin idle rd_cnt", {28'd0, rd_cnt}, 32'd3);
    chk("pin idle wr_cnt", {28'd0, wr_cnt}, 32'd3);

    // top word of the range, back-to-back write/read
    dbg_addr = 12'hFFF;
    wr(32'h3FFC, 4'hf, 32'h1234_5678);
    rd(32'h3FFC);
    chk("pin top word", rdata, 32'h1234_5678);
    chk("pin top word no err", {31'd0, err_valid}, 32'd0);

    // range error, first-error sticky
    dbg_addr = 12'd0;
    wr(32'h4000, 4'hf, 32'hCAFE_F00D);
    chk("pin range err_valid", {31'd0, err_valid}, 32'd1);
    chk("pin range err_addr", err_addr, 32'h4000);
    chk("pin range err_cause", {30'd0, err_cause}, 32'd1);
    rd(32'h4004);
    chk("pin range rdata", rdata, 32'h0);
    chk("pin range sticky addr", err_addr, 32'h4000);
    rd(32'h0);  // wraps onto word 0 only if aliasing were wrong

    // misaligned after reset
    rst1();
    rd(32'h13);
    chk("pin misal rdata", rdata, 32'hDEAD_BEEF);
    chk("pin misal cause", {30'd0, err_cause}, 32'd2);
    chk("pin misal addr", err_addr, 32'h13);
    rd(32'h4001);
    chk("pin misal sticky", {30'd0, err_cause}, 32'd2);
    rst1();
    rd(32'h4001);
    chk("pin both cause", {30'd0, err_cause}, 32'd3);

    // counter wrap: 20 reads from reset -> 20 mod 16
    rst1();
    for (int i = 0; i < 20; i++) rd(32'h20);
    chk("pin rd_cnt wrap", {28'd0, rd_cnt}, 32'd4);

    // reset mid-stream, with a write landing during reset
    wr(32'h30, 4'hf, 32'h5A5A_5A5A);
    step(1'b1, 1'b1, 4'hf, 32'h34, 32'h0102_0304);
    chk("pin rst rdata", rdata, 32'h0);
    chk("pin rst wr_cnt", {28'd0, wr_cnt}, 32'd0);
    chk("pin rst err_valid", {31'd0, err_valid}, 32'd0);
    rd(32'h30);
    chk("pin rst persist", rdata, 32'h5A5A_5A5A);
    rd(32'h34);
    chk("pin rst write lands", rdata, 32'h0102_0304);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    chk_on = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder side of the CPU data SRAM interface: accepts en/wen/addr/wdata from the execute stage and returns rdata one cycle later for the memory stage to consume.
- Serves as the synthesizable data memory behind the pipeline in simulation and FPGA builds.
- Adds byte-lane writes, range/alignment error capture, access counters and a debug backdoor read port.

Parameters:
- ADDR_W, 12, word-address width; depth = 2**ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned.
- CNT_W, 32, width of the read and write access counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- data_sram_en  in  1  access enable
- data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]
- data_sram_addr  in  32  byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, valid the cycle after the accepted access
- err_valid  out  1  sticky error flag
- err_addr  out  32  address of the first erroneous access
- err_cause  out  2  01 = out of range, 10 = misaligned (addr[1:0]≠0), 11 = both
- rd_cnt  out  CNT_W  number of accepted reads
- wr_cnt  out  CNT_W  number of accepted writes
- dbg_addr  in  ADDR_W  backdoor word index
- dbg_rdata  out  32  combinational backdoor read of mem[dbg_addr]

Behaviour:
- Reset, synchronous: data_sram_rdata=0, err_valid=0, err_addr=0, err_cause=0, rd_cnt=0, wr_cnt=0. The memory array is NOT cleared; its contents persist across reset.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[ADDR_W+1:2].
  - in_range = off < 4*2**ADDR_W, computed as an unsigned 32-bit comparison; off wraps when addr < BASE_ADDR, so that case is out of range.
  - misaligned = addr[1:0] ≠ 0. The low bits are ignored for indexing.
- Access type:
  - Write: en=1 and wen≠0, in range.
  - Read: en=1 and wen=0.
  - Idle: en=0. A wen value is ignored when en=0.
- Write, 1-cycle:
  - At the clock edge, each enabled byte lane of mem[idx] is updated; disabled lanes keep their value.
  - data_sram_rdata is loaded with the pre-write word (read-first).
  - wr_cnt increments.
- Read, 1-cycle latency: data_sram_rdata <= mem[idx] at the edge; rd_cnt increments.
- Idle: data_sram_rdata holds its previous value. No counter change.
- Out-of-range access:
  - Write: no memory update.
  - Read: data_sram_rdata <= 0.
  - Counters still increment.
  - If err_valid=0: err_valid=1, err_addr=addr, err_cause updated.
- Misaligned access in range: executed normally at idx; the error is captured as for out-of-range.
- Error capture is first-error-only and sticky until reset. Later errors do not overwrite err_addr or err_cause.
- Back-to-back write then read of the same address: the read returns the newly written data; sequential array semantics give this naturally.
- Counters wrap modulo 2**CNT_W without saturation.
- Reset asserted in the same cycle as an access: reset wins for all registers and counters, but a write in that cycle still updates the memory array, because the array is not reset-controlled.
- dbg_rdata is purely combinational and reflects writes from the next cycle onward.

Decomposition:
- Shared package: DATA_W=32, WSTRB_W=4, and the err_cause encodings ERR_RANGE=2'b01 and ERR_ALIGN=2'b10.
- One sub-module, sram_bytewe_array: a 2**ADDR_W x 32 array with byte write enables, read-first registered output and an asynchronous debug read port. It keeps the array inferable as block RAM plus distributed read.
- Decode, error and counter logic stay in data_sram_resp.

Test Plan:
- Write then read: write addr 0x10, wen=4'hf, wdata 0xDEADBEEF; next cycle read 0x10 -> rdata=0xDEADBEEF one cycle after the read; wr_cnt=1, rd_cnt=1.
- Byte lanes: preload 0x11223344 at 0x20; write wen=4'b0101, wdata 0xAABBCCDD -> read 0x20 returns 0x11BB33DD; dbg_addr=8 shows the same value.
- Hold on idle: read 0x10 (0xDEADBEEF), then 3 cycles en=0 with wen=4'hf and wdata=0 -> rdata stays 0xDEADBEEF; memory unchanged; counters unchanged.
- Range error: with ADDR_W=12 and BASE_ADDR=0:
  - Write 0x4000 -> no array change, err_valid=1, err_addr=0x4000, err_cause=01.
  - Then read 0x4004 -> rdata=0, err_addr still 0x4000.
- Misaligned: after reset, read 0x13 -> returns mem[4], err_cause=10, err_addr=0x13.
- Reset mid-stream: write 0x30=0x5A5A5A5A, then assert reset one cycle -> rdata=0, counters=0, err_valid=0; after reset, read 0x30 returns 0x5A5A5A5A.
